simple_8bit: RTL and testbench
==============================

# simple_8bit

Basic 8-bit parallel-in/parallel-out data register. It captures the 8-bit input bus `D` on every rising edge of `clk` and presents it on `Q` one cycle later. It is the leaf storage element for the sequential-design register family, used wherever a one-cycle delay or a pipeline stage on an 8-bit bus is needed. An optional load enable is compiled in by macro.

## Interface
- `WIDTH`, default 8: data bus width in bits. Only 8 is required to be supported; other values must elaborate without change.
- `RESET_VALUE`, default 8'h00: value loaded into `Q` by reset.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `rst`  input  1  synchronous, active-high reset; one clock, reset sampled only on rising `clk`.
- `D`  input  WIDTH  data to capture.
- `en`  input  1  load enable; present only when `SIMPLE_8BIT_LOAD_EN` is defined.
- `Q`  output  WIDTH  registered data.

## Operation
- All state is held in WIDTH flip-flops driving `Q` directly. There is no combinational path from `D` to `Q`.
- On each rising `clk`, the following rules apply in priority order:
  - `rst`=1: `Q` <= RESET_VALUE (8'h00), regardless of `D` and `en`.
  - else, if the enable is compiled in and `en`=0: `Q` holds its value.
  - else: `Q` <= `D`, all bits in parallel with no transformation.
- Reset is synchronous. Asserting `rst` between edges has no effect until the next rising edge. Deasserting it takes effect at the next edge, which loads `D`.
- `Q` is undefined (X) from power-up until the first reset edge or the first load edge. The bench must not check `Q` before then.
- There is no wrap-around, overflow or arithmetic; the block does pure storage.

## Timing
- Latency is 1 cycle. A `D` value stable at rising edge N appears on `Q` immediately after edge N and persists until edge N+1.
- `D` may change at any time between edges. Only the value at the rising edge matters, with normal setup/hold.
- Reset behaves the same way: `rst` high at edge N gives `Q`=8'h00 after edge N.
- Throughput is one new word every cycle. There is no handshake.

## Configuration
- Macro `SIMPLE_8BIT_LOAD_EN`:
  - Defined: the `en` port exists. `en`=0 holds `Q`; `en`=1 loads `D`. Reset still overrides `en`.
  - Undefined: there is no `en` port, and the register loads `D` every cycle that `rst` is low.

## Structure
- Shared package `simple_8bit_pkg`:
  - `SIMPLE_8BIT_WIDTH` = 8
  - `SIMPLE_8BIT_RESET` = 8'h00
  - typedef `simple_8bit_word_t` (logic [7:0])
- One sub-module is natural: `simple_8bit_bit`, a single-bit D flip-flop with synchronous reset and optional enable. It is instantiated WIDTH times with a generate loop, each copy driving one bit of `Q`.

## Test plan
- Clock period 4 ns, with the first rising edge at 2 ns. Hold `rst`=1 for 2 edges, then release. Require `Q`=8'h00 after the first reset edge.
- Apply `D`=8'h00, then 8'hFF, then 8'h00, then 8'hFF, changing `D` mid-cycle. Require `Q` to equal the prior edge's `D` each cycle: 00, FF, 00, FF.
- Apply `D`=8'hA5 for one cycle, then 8'h5A. Require `Q`=A5, then 5A, which checks bit-lane independence with no swapping.
- With `Q`=8'hFF, assert `rst` mid-cycle while `D`=8'hFF. Require `Q` to stay FF until the next rising edge, then become 00. Release `rst` and require `Q`=FF at the following edge.
- With `SIMPLE_8BIT_LOAD_EN` defined:
  - `en`=0 with `D`=8'h3C for 3 cycles: `Q` holds its previous value (8'hFF).
  - `en`=1: `Q`=3C at the next edge.
  - `rst`=1 while `en`=0: `Q`=00.
- Toggle `D` between edges with no clock edge occurring. Require `Q` to stay unchanged, proving there is no combinational feed-through.

Source files
------------

// File: rtl/simple_8bit_pkg.sv
// simple_8bit_pkg: shared constants and word type for the simple_8bit
// register family. Optional load enable is selected by SIMPLE_8BIT_LOAD_EN.
package simple_8bit_pkg;

  localparam int SIMPLE_8BIT_WIDTH = 8;

  typedef logic [SIMPLE_8BIT_WIDTH-1:0] simple_8bit_word_t;

  localparam simple_8bit_word_t SIMPLE_8BIT_RESET = 8'h00;

endpackage : simple_8bit_pkg

// File: rtl/simple_8bit_bit.sv
// simple_8bit_bit: one storage bit of the simple_8bit register.
// D flip-flop with synchronous active-high reset and a load enable.
// The enable is tied high by the parent when SIMPLE_8BIT_LOAD_EN is undefined.
module simple_8bit_bit #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic q
);

  logic r_q;

  // Reset wins over enable; with enable low the bit simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RESET_BIT;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : simple_8bit_bit

// File: rtl/simple_8bit.sv
// simple_8bit: WIDTH-bit parallel-in/parallel-out register, one cycle latency.
// Define SIMPLE_8BIT_LOAD_EN to add the 'en' load-enable port; otherwise the
// register loads D on every clock where rst is low.
module simple_8bit
  import simple_8bit_pkg::*;
#(
  parameter int               WIDTH       = SIMPLE_8BIT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = SIMPLE_8BIT_RESET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
`ifdef SIMPLE_8BIT_LOAD_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] Q
);

  logic w_en;

`ifdef SIMPLE_8BIT_LOAD_EN
  assign w_en = en;
`else
  assign w_en = 1'b1;
`endif

  // Each lane is an independent flop; Q is driven straight from the flops,
  // so there is no combinational path from D to Q.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      simple_8bit_bit #(
        .RESET_BIT(RESET_VALUE[gi])
      ) u_bit (
        .clk(clk),
        .rst(rst),
        .d  (D[gi]),
        .en (w_en),
        .q  (Q[gi])
      );
    end
  endgenerate

endmodule : simple_8bit

// File: tb/tb_simple_8bit.sv
// tb_simple_8bit: directed self-checking bench for simple_8bit.
// Works with and without SIMPLE_8BIT_LOAD_EN defined.
`timescale 1ns/1ps
module tb_simple_8bit;
  import simple_8bit_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  simple_8bit_word_t D;
  logic              en;
  simple_8bit_word_t Q;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: expected register contents and whether they are defined.
  simple_8bit_word_t m_q;
  bit                m_valid = 1'b0;

  simple_8bit #(
    .WIDTH      (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .D  (D),
`ifdef SIMPLE_8BIT_LOAD_EN
    .en (en),
`endif
    .Q  (Q)
  );

  // 4 ns period, first rising edge at 2 ns.
  always #2 clk = ~clk;

  // Model: reset loads zero, otherwise a load (if enabled) takes D, else hold.
  always @(posedge clk) begin
    bit load;
`ifdef SIMPLE_8BIT_LOAD_EN
    load = (en === 1'b1);
`else
    load = 1'b1;
`endif
    if (rst === 1'b1) begin
      m_q     = 8'h00;
      m_valid = 1'b1;
    end else if (load) begin
      m_q     = D;
      m_valid = 1'b1;
    end
  end

  // Compare DUT against the model 1 ns after every rising edge.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      n_cmp++;
      if (Q !== m_q) begin
        n_fail++;
        $display("FAIL model_q t=%0t Q=%h expected=%h", $time, Q, m_q);
      end else begin
        $display("cycle t=%0t D=%h rst=%b Q=%h ok", $time, D, rst, Q);
      end
    end
  end

  task automatic check(input string name, input simple_8bit_word_t act,
                       input simple_8bit_word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t Q=%h expected=%h", name, $time, act, exp);
    end else begin
      $display("check %s t=%0t Q=%h ok", name, $time, act);
    end
  endtask

  // Wait for the next rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change D (and optionally other inputs) mid-cycle, then advance one edge.
  task automatic step_d(input simple_8bit_word_t d);
    @(negedge clk);
    D = d;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    D   = 8'h77;
    en  = 1'b1;

    // Reset held for two edges.
    tick();
    check("reset_edge1", Q, 8'h00);
    tick();
    check("reset_edge2", Q, 8'h00);

    // Release reset mid-cycle; next edge loads D.
    @(negedge clk);
    rst = 1'b0;
    D   = 8'h00;
    tick();
    check("load_00a", Q, 8'h00);
    step_d(8'hFF);
    check("load_ffa", Q, 8'hFF);
    step_d(8'h00);
    check("load_00b", Q, 8'h00);
    step_d(8'hFF);
    check("load_ffb", Q, 8'hFF);

    // Lane independence.
    step_d(8'hA5);
    check("lane_a5", Q, 8'hA5);
    step_d(8'h5A);
    check("lane_5a", Q, 8'h5A);

    // Mid-cycle reset with Q=FF: no effect until the next edge.
    step_d(8'hFF);
    check("pre_rst_ff", Q, 8'hFF);
    #0.5;
    rst = 1'b1;
    #0.5;
    check("rst_mid_hold", Q, 8'hFF);
    tick();
    check("rst_applied", Q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_release", Q, 8'hFF);

`ifdef SIMPLE_8BIT_LOAD_EN
    // Enable low holds; enable high loads; reset overrides enable low.
    @(negedge clk);
    en = 1'b0;
    D  = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("en0_hold", Q, 8'hFF);
    end
    @(negedge clk);
    en = 1'b1;
    tick();
    check("en1_load", Q, 8'h3C);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_over_en", Q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    D   = 8'hFF;
    tick();
    check("en_reload", Q, 8'hFF);
`endif

    // No feed-through: toggle D between edges, Q must not move.
    step_d(8'hC3);
    check("ft_base", Q, 8'hC3);
    D = 8'h11;
    #0.5;
    check("ft_11", Q, 8'hC3);
    D = 8'hEE;
    #0.5;
    check("ft_ee", Q, 8'hC3);
    D = 8'h00;
    #0.5;
    check("ft_00", Q, 8'hC3);
    D = 8'h96;
    tick();
    check("ft_next", Q, 8'h96);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_simple_8bit
